// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: N-channel arbiter and bus master for the multiplexed
// address/data RTC chip bus. Each transfer runs ADDR -> GAP1 -> DATA -> GAP2
// -> DONE. A locked channel keeps the bus for back-to-back transfers.
module rtc_bus_arbiter #(
    parameter int N_CH     = 4,
    parameter int ARB_MODE = 0,
    parameter int T_STB    = 2,
    parameter int T_GAP    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   wr_rd,
    input  logic [N_CH-1:0]   lock,
    input  logic [8*N_CH-1:0] addr,
    input  logic [8*N_CH-1:0] wdata,
    output logic [N_CH-1:0]   grant,
    output logic [N_CH-1:0]   done,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    inout  wire  [7:0]        rtc_bus
);
    localparam int PW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CMAX = (T_STB > T_GAP) ? T_STB : T_GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_DATA,
        S_GAP2,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] cur;
    logic [PW-1:0] ptr;
    logic          wr_l;
    logic          bus_oe;
    logic [7:0]    bus_out;
    logic [7:0]    wdata_l;

    logic [PW-1:0] win;
    logic [PW-1:0] sel;
    logic          arb_go;
    logic          relatch;
    logic          last_stb;
    logic          last_gap;

    // First requester at or after the start index; start is 0 for fixed priority.
    function automatic logic [PW-1:0] pick_winner(input logic [N_CH-1:0] r,
                                                  input logic [PW-1:0] p);
        int            base;
        int            idx;
        logic [PW-1:0] w;
        w    = '0;
        base = (ARB_MODE == 1) ? int'(p) : 0;
        // Scan from the far end so the nearest requester is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (base + k) % N_CH;
            if (r[idx]) w = PW'(idx);
        end
        return w;
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [PW-1:0] i);
        return N_CH'(1) << i;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (i == PW'(N_CH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign win      = pick_winner(req, ptr);
    assign arb_go   = (state == S_IDLE) && (|req);
    assign relatch  = (state == S_DONE) && lock[cur] && req[cur];
    assign sel      = arb_go ? win : cur;
    assign last_stb = (cnt == CW'(T_STB - 1));
    assign last_gap = (cnt == CW'(T_GAP - 1));

    assign rtc_bus  = bus_oe ? bus_out : 8'hzz;

    // Bus data path: address loaded at grant/relatch, write data swapped in entering DATA.
    always_ff @(posedge clk) begin
        if (arb_go || relatch) begin
            bus_out <= addr[8*sel +: 8];
            wdata_l <= wdata[8*sel +: 8];
        end else if ((state == S_GAP1) && last_gap) begin
            bus_out <= wdata_l;
        end
    end

    // Transfer sequencer with registered bus strobes, grant/done and read capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cur    <= '0;
            ptr    <= '0;
            wr_l   <= 1'b0;
            grant  <= '0;
            done   <= '0;
            rdata  <= 8'h00;
            busy   <= 1'b0;
            a_d    <= 1'b1;
            cs     <= 1'b1;
            rd     <= 1'b1;
            wr     <= 1'b1;
            bus_oe <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_go) begin
                        state  <= S_ADDR;
                        cnt    <= '0;
                        cur    <= win;
                        wr_l   <= wr_rd[win];
                        grant  <= onehot(win);
                        busy   <= 1'b1;
                        cs     <= 1'b0;
                        a_d    <= 1'b0;
                        wr     <= 1'b0;
                        bus_oe <= 1'b1;
                    end
                end
                S_ADDR: begin
                    if (last_stb) begin
                        state  <= S_GAP1;
                        cnt    <= '0;
                        cs     <= 1'b1;
                        a_d    <= 1'b1;
                        wr     <= 1'b1;
                        bus_oe <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP1: begin
                    if (last_gap) begin
                        state  <= S_DATA;
                        cnt    <= '0;
                        cs     <= 1'b0;
                        a_d    <= 1'b1;
                        wr     <= ~wr_l;
                        rd     <= wr_l;
                        bus_oe <= wr_l;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_stb) begin
                        state  <= S_GAP2;
                        cnt    <= '0;
                        cs     <= 1'b1;
                        wr     <= 1'b1;
                        rd     <= 1'b1;
                        bus_oe <= 1'b0;
                        if (!wr_l) rdata <= rtc_bus;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP2: begin
                    if (last_gap) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        done  <= grant;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ptr <= next_ptr(cur);
                    if (relatch) begin
                        // Locked burst: straight back to ADDR, grant held, no arbitration.
                        state  <= S_ADDR;
                        cnt    <= '0;
                        wr_l   <= wr_rd[cur];
                        cs     <= 1'b0;
                        a_d    <= 1'b0;
                        wr     <= 1'b0;
                        bus_oe <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Testbench for rtc_bus_arbiter: one fixed-priority instance with a small RTC
// model (returns address + 0x15 on reads, captures written data), and one
// round-robin instance used for the fairness sequence.
module tb_rtc_bus_arbiter;
    logic        clk;
    logic        reset;

    logic [3:0]  req, wr_rd, lock;
    logic [31:0] addr, wdata;
    logic [3:0]  grant, done;
    logic [7:0]  rdata;
    logic        busy, a_d, cs, rd, wr;
    wire  [7:0]  rtc_bus;

    logic [3:0]  req_rr, wr_rd_rr, lock_rr;
    logic [31:0] addr_rr, wdata_rr;
    logic [3:0]  grant_rr, done_rr;
    logic [7:0]  rdata_rr;
    logic        busy_rr, a_d_rr, cs_rr, rd_rr, wr_rr;
    wire  [7:0]  rtc_bus_rr;

    logic [7:0]  m_addr;
    logic [7:0]  m_wcap;

    int n_cmp;
    int n_fail;

    rtc_bus_arbiter #(.N_CH(4), .ARB_MODE(0), .T_STB(2), .T_GAP(2)) dut (
        .clk(clk), .reset(reset), .req(req), .wr_rd(wr_rd), .lock(lock),
        .addr(addr), .wdata(wdata), .grant(grant), .done(done), .rdata(rdata),
        .busy(busy), .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .rtc_bus(rtc_bus)
    );

    rtc_bus_arbiter #(.N_CH(4), .ARB_MODE(1), .T_STB(2), .T_GAP(2)) dut_rr (
        .clk(clk), .reset(reset), .req(req_rr), .wr_rd(wr_rd_rr), .lock(lock_rr),
        .addr(addr_rr), .wdata(wdata_rr), .grant(grant_rr), .done(done_rr),
        .rdata(rdata_rr), .busy(busy_rr), .a_d(a_d_rr), .cs(cs_rr), .rd(rd_rr),
        .wr(wr_rr), .rtc_bus(rtc_bus_rr)
    );

    // RTC chip model: drives address+0x15 while read strobe is low.
    assign rtc_bus = (!cs && !rd) ? (m_addr + 8'h15) : 8'hzz;

    always @(posedge clk) begin
        if (!cs && !a_d && !wr) m_addr <= rtc_bus;
        if (!cs && a_d && !wr)  m_wcap <= rtc_bus;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cs,a_d,wr,rd} at cycle k of a transfer (k=0 is the grant cycle).
    function automatic logic [3:0] exp_strobe(input int k, input logic w);
        if (k < 2) return 4'b0001;
        if (k >= 4 && k < 6) return w ? 4'b0101 : 4'b0110;
        return 4'b1111;
    endfunction

    task automatic clear_inputs();
        req = '0; wr_rd = '0; lock = '0; addr = '0; wdata = '0;
        req_rr = '0; wr_rd_rr = '0; lock_rr = '0; addr_rr = '0; wdata_rr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({grant, done, rdata, busy, a_d, cs, rd, wr} !== {4'h0, 4'h0, 8'h00, 1'b0, 4'b1111}) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", {grant, done, rdata, busy, a_d, cs, rd, wr},
                     {4'h0, 4'h0, 8'h00, 1'b0, 4'b1111});
        end
        n_cmp++;
        if (rtc_bus !== 8'hzz && rtc_bus !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus got %h want released", rtc_bus);
        end
        n_cmp++;
        if ({grant_rr, busy_rr, cs_rr, rd_rr, wr_rr} !== 8'b0000_0111) begin
            n_fail++;
            $display("FAIL reset_rr got %b want 00000111", {grant_rr, busy_rr, cs_rr, rd_rr, wr_rr});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic [12:0] e;
        logic [7:0]  eb;
        logic        rel;
        clear_inputs();
        req = 4'b0010; wr_rd = 4'b0010; addr[15:8] = 8'h21; wdata[15:8] = 8'h45;
        tick();
        req = '0; addr = '0; wdata = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) e = {4'b0010, (k == 8) ? 4'b0010 : 4'b0000, 1'b1, exp_strobe(k, 1'b1)};
            else       e = {4'b0000, 4'b0000, 1'b0, 4'b1111};
            rel = 1'b0;
            if (k < 2) eb = 8'h21;
            else if (k >= 4 && k < 6) eb = 8'h45;
            else begin eb = 8'h00; rel = 1'b1; end
            n_cmp++;
            if ({grant, done, busy, cs, a_d, wr, rd} !== e) begin
                n_fail++;
                $display("FAIL write_ctl k=%0d got %b want %b", k, {grant, done, busy, cs, a_d, wr, rd}, e);
            end
            n_cmp++;
            if (rel ? (rtc_bus !== 8'hzz && rtc_bus !== 8'h00) : (rtc_bus !== eb)) begin
                n_fail++;
                $display("FAIL write_bus k=%0d got %h want %h", k, rtc_bus, eb);
            end
            tick();
        end
        n_cmp++;
        if (m_wcap !== 8'h45) begin
            n_fail++;
            $display("FAIL write_capture got %h want 45", m_wcap);
        end
    endtask

    task automatic test_single_read();
        logic [12:0] e;
        logic [7:0]  eb;
        logic        rel;
        clear_inputs();
        req = 4'b0100; wr_rd = 4'b0000; addr[23:16] = 8'h22;
        tick();
        req = '0; addr = '0;
        for (int k = 0; k < 9; k++) begin
            e = {4'b0100, (k == 8) ? 4'b0100 : 4'b0000, 1'b1, exp_strobe(k, 1'b0)};
            rel = 1'b0;
            if (k < 2) eb = 8'h22;
            else if (k >= 4 && k < 6) eb = 8'h37;
            else begin eb = 8'h00; rel = 1'b1; end
            n_cmp++;
            if ({grant, done, busy, cs, a_d, wr, rd} !== e) begin
                n_fail++;
                $display("FAIL read_ctl k=%0d got %b want %b", k, {grant, done, busy, cs, a_d, wr, rd}, e);
            end
            n_cmp++;
            if (rel ? (rtc_bus !== 8'hzz && rtc_bus !== 8'h00) : (rtc_bus !== eb)) begin
                n_fail++;
                $display("FAIL read_bus k=%0d got %h want %h", k, rtc_bus, eb);
            end
            if (k == 8) begin
                n_cmp++;
                if (rdata !== 8'h37) begin
                    n_fail++;
                    $display("FAIL read_rdata got %h want 37", rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        clear_inputs();
        req = 4'b1001; wr_rd = 4'b1001; addr[7:0] = 8'h30; addr[31:24] = 8'h31;
        tick();
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL contention_first got %b want 0001", grant);
        end
        req[0] = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 8) begin
                n_cmp++;
                if ({grant, done} !== 8'b0001_0001) begin
                    n_fail++;
                    $display("FAIL contention_done0 got %b want 00010001", {grant, done});
                end
            end
            if (k == 9) begin
                n_cmp++;
                if ({grant, busy} !== 5'b0000_0) begin
                    n_fail++;
                    $display("FAIL contention_idle got %b want 00000", {grant, busy});
                end
            end
            if (k == 10) begin
                n_cmp++;
                if (grant !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL contention_second got %b want 1000", grant);
                end
                req = '0;
            end
            if (k == 18) begin
                n_cmp++;
                if (done !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL contention_done3 got %b want 1000", done);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        clear_inputs();
        req_rr = 4'b1111; wr_rd_rr = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            eg = 4'b0001 << (t % 4);
            for (int c = 0; c < 20 && grant_rr == 4'b0000; c++) tick();
            n_cmp++;
            if (grant_rr !== eg) begin
                n_fail++;
                $display("FAIL rr_grant t=%0d got %b want %b", t, grant_rr, eg);
            end
            repeat (8) tick();
            n_cmp++;
            if (done_rr !== eg) begin
                n_fail++;
                $display("FAIL rr_done t=%0d got %b want %b", t, done_rr, eg);
            end
            tick();
            n_cmp++;
            if (grant_rr !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_idle t=%0d got %b want 0000", t, grant_rr);
            end
        end
        req_rr = '0;
        repeat (3) tick();
    endtask

    task automatic test_lock_burst();
        clear_inputs();
        req = 4'b1000; lock = 4'b1000; wr_rd = 4'b0000; addr[31:24] = 8'h21;
        tick();
        n_cmp++;
        if ({grant, rtc_bus} !== {4'b1000, 8'h21}) begin
            n_fail++;
            $display("FAIL lock_first got %h want 821", {grant, rtc_bus});
        end
        req[0] = 1'b1; wr_rd[0] = 1'b1; addr[7:0] = 8'h10; wdata[7:0] = 8'h99;
        addr[31:24] = 8'h22;
        for (int k = 1; k <= 37; k++) begin
            tick();
            case (k)
                8, 17, 26: begin
                    n_cmp++;
                    if ({grant, done, rdata} !== {4'b1000, 4'b1000, 8'h36 + 8'(k / 9)}) begin
                        n_fail++;
                        $display("FAIL lock_done k=%0d got %h want %h", k, {grant, done, rdata},
                                 {4'b1000, 4'b1000, 8'h36 + 8'(k / 9)});
                    end
                end
                9, 18: begin
                    n_cmp++;
                    if ({grant, cs, a_d, rtc_bus} !== {4'b1000, 2'b00, 8'h21 + 8'(k / 9)}) begin
                        n_fail++;
                        $display("FAIL lock_relatch k=%0d got %h want %h", k, {grant, cs, a_d, rtc_bus},
                                 {4'b1000, 2'b00, 8'h21 + 8'(k / 9)});
                    end
                    if (k == 9) addr[31:24] = 8'h23;
                    if (k == 18) begin lock = '0; req[3] = 1'b0; end
                end
                27: begin
                    n_cmp++;
                    if (grant !== 4'b0000) begin
                        n_fail++;
                        $display("FAIL lock_release got %b want 0000", grant);
                    end
                end
                28: begin
                    n_cmp++;
                    if (grant !== 4'b0001) begin
                        n_fail++;
                        $display("FAIL lock_ch0_grant got %b want 0001", grant);
                    end
                    req = '0;
                end
                36: begin
                    n_cmp++;
                    if ({done, m_wcap} !== {4'b0001, 8'h99}) begin
                        n_fail++;
                        $display("FAIL lock_ch0_done got %h want 199", {done, m_wcap});
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_transfer();
        clear_inputs();
        req = 4'b0010; wr_rd = 4'b0010; addr[15:8] = 8'h55; wdata[15:8] = 8'hAA;
        tick();
        req = '0;
        repeat (4) tick();
        n_cmp++;
        if ({wr, rtc_bus} !== {1'b0, 8'hAA}) begin
            n_fail++;
            $display("FAIL midreset_pre got %h want 0aa", {wr, rtc_bus});
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({grant, done, busy, cs, a_d, wr, rd} !== {4'b0000, 4'b0000, 1'b0, 4'b1111}) begin
            n_fail++;
            $display("FAIL midreset_ctl got %b want 0000000001111", {grant, done, busy, cs, a_d, wr, rd});
        end
        n_cmp++;
        if (rtc_bus !== 8'hzz && rtc_bus !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_bus got %h want released", rtc_bus);
        end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({done, busy} !== 5'b0000_0) begin
                n_fail++;
                $display("FAIL midreset_nodone k=%0d got %b want 00000", k, {done, busy});
            end
        end
        req = 4'b0100; wr_rd = 4'b0100; addr[23:16] = 8'h66; wdata[23:16] = 8'h77;
        tick();
        n_cmp++;
        if ({grant, rtc_bus} !== {4'b0100, 8'h66}) begin
            n_fail++;
            $display("FAIL midreset_regrant got %h want 466", {grant, rtc_bus});
        end
        req = '0;
        repeat (8) tick();
        n_cmp++;
        if ({done, m_wcap} !== {4'b0100, 8'h77}) begin
            n_fail++;
            $display("FAIL midreset_redone got %h want 477", {done, m_wcap});
        end
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_round_robin();
        test_lock_burst();
        test_reset_mid_transfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
